// File: rtl/apb_master_arb.sv
// Round-robin arbiter that lets N_REQ requesters share a single APB master port.
// Exactly one APB transfer is in flight: IDLE (grant) -> SETUP -> ACCESS -> IDLE.
module apb_master_arb #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        pclk,
    input  logic                        preset_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_slverr,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [DATA_WIDTH-1:0]       pwdata,
    input  logic                        pready,
    input  logic [DATA_WIDTH-1:0]       prdata,
    input  logic                        pslverr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] xfer_id;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_found;
    logic [ID_W-1:0] ptr_next;

    // Rotating search: the first valid requester at or after ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(ptr) + i) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Acceptance is only offered in IDLE and never while reset is held.
    assign req_ready = (preset_n && state == S_IDLE && gnt_found)
                     ? (N_REQ'(1) << gnt_idx) : '0;

    assign psel    = (state == S_SETUP) || (state == S_ACCESS);
    assign penable = (state == S_ACCESS);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            xfer_id    <= '0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        paddr   <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        pwrite  <= req_write[gnt_idx];
                        pwdata  <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        xfer_id <= gnt_idx;
                        ptr     <= ptr_next;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= xfer_id;
                        rsp_slverr <= pslverr;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed scenarios followed by random
// transfers, checked against a transaction-level round-robin/APB model.
module tb_apb_master_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk = 1'b0;
    logic            preset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_wdata;
    logic            rsp_valid;
    logic [0:0]      rsp_id;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;

    apb_master_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state
    int          m_ptr = 0;
    logic [31:0] m_last_addr = '0;
    logic [31:0] m_last_wdata = '0;
    logic        m_last_write = 1'b0;
    bit          m_pend = 1'b0;
    int          m_rsp_id = 0;
    logic [31:0] m_rsp_rdata = '0;
    logic        m_rsp_serr = 1'b0;
    int          pen_cycles;

    logic [31:0] ad [N];
    logic [31:0] wd [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv;
        @(posedge pclk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_reqs;
        for (int k = 0; k < N; k++) begin
            ad[k] = $urandom;
            wd[k] = $urandom;
        end
    endtask

    task automatic apply_reqs(input logic [N-1:0] mask, input logic [N-1:0] wmask);
        req_valid = mask;
        req_write = wmask;
        for (int k = 0; k < N; k++) begin
            req_addr[k*AW +: AW]  = ad[k];
            req_wdata[k*DW +: DW] = wd[k];
        end
    endtask

    task automatic reset_zero_checks(input string tag);
        chk({tag, "_psel"}, 64'(psel), 64'd0);
        chk({tag, "_penable"}, 64'(penable), 64'd0);
        chk({tag, "_paddr"}, 64'(paddr), 64'd0);
        chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
        chk({tag, "_pwrite"}, 64'(pwrite), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_rsp_slverr"}, 64'(rsp_slverr), 64'd0);
    endtask

    // One arbitration cycle plus, if granted, the full APB transfer.
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_xfer(input logic [N-1:0] mask, input logic [N-1:0] wmask,
                            input int waits, input logic serr, input logic [31:0] rd,
                            input bit rst_in_wait);
        int g;
        apply_reqs(mask, wmask);
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'(($urandom) & 1);
        g = pick(mask);
        @(negedge pclk);
        chk("rsp_valid_idle", 64'(rsp_valid), 64'(m_pend));
        if (m_pend) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_rdata));
            chk("rsp_slverr", 64'(rsp_slverr), 64'(m_rsp_serr));
        end
        m_pend = 1'b0;
        chk("idle_psel", 64'(psel), 64'd0);
        chk("idle_penable", 64'(penable), 64'd0);
        chk("idle_paddr_hold", 64'(paddr), 64'(m_last_addr));
        chk("grant", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g < 0) begin
            adv();
            return;
        end
        m_ptr        = (g + 1) % N;
        m_last_addr  = ad[g];
        m_last_wdata = wd[g];
        m_last_write = wmask[g];
        adv();
        // In-flight transfer must ignore request-side changes
        req_valid = N'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_write = N'($urandom);
        @(negedge pclk);
        chk("setup_psel", 64'(psel), 64'd1);
        chk("setup_penable", 64'(penable), 64'd0);
        chk("setup_paddr", 64'(paddr), 64'(m_last_addr));
        chk("setup_pwrite", 64'(pwrite), 64'(m_last_write));
        chk("setup_pwdata", 64'(pwdata), 64'(m_last_wdata));
        chk("setup_ready", 64'(req_ready), 64'd0);
        chk("setup_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rsp_id_hold", 64'(rsp_id), 64'(m_rsp_id));
        chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(m_rsp_rdata));
        adv();
        pen_cycles = 0;
        for (int w = 0; w <= waits; w++) begin
            pready  = (w == waits);
            prdata  = (w == waits) ? rd : $urandom;
            pslverr = (w == waits) ? serr : 1'(($urandom) & 1);
            @(negedge pclk);
            if (penable === 1'b1) pen_cycles++;
            chk("access_psel", 64'(psel), 64'd1);
            chk("access_paddr", 64'(paddr), 64'(m_last_addr));
            chk("access_pwdata", 64'(pwdata), 64'(m_last_wdata));
            chk("access_ready", 64'(req_ready), 64'd0);
            chk("access_rsp_valid", 64'(rsp_valid), 64'd0);
            if (rst_in_wait && w == 1) begin
                preset_n = 1'b0;
                #1;
                reset_zero_checks("midrst");
                m_ptr = 0; m_last_addr = '0; m_last_wdata = '0; m_last_write = 1'b0;
                m_pend = 1'b0; m_rsp_id = 0; m_rsp_rdata = '0; m_rsp_serr = 1'b0;
                adv();
                req_valid = 2'b10;
                pready    = 1'b0;
                @(negedge pclk);
                reset_zero_checks("inrst");
                adv();
                preset_n = 1'b1;
                return;
            end
            adv();
        end
        chk("penable_cycles", 64'(pen_cycles), 64'(waits + 1));
        m_pend      = 1'b1;
        m_rsp_id    = g;
        m_rsp_rdata = wmask[g] ? 32'd0 : rd;
        m_rsp_serr  = serr;
    endtask

    initial begin
        preset_n  = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        rand_reqs();
        #12;
        reset_zero_checks("reset");
        adv();
        adv();
        preset_n = 1'b1;
        adv();

        // Nothing requested: stay idle
        run_xfer(2'b00, 2'b00, 0, 1'b0, 32'h0, 1'b0);

        // Single write from requester 0
        ad[0] = 32'h10; wd[0] = 32'hA5A5_0001;
        run_xfer(2'b01, 2'b01, 0, 1'b0, 32'h1234_5678, 1'b0);

        // Read with three wait states from requester 1
        ad[1] = 32'h20;
        run_xfer(2'b10, 2'b00, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        run_xfer(2'b00, 2'b00, 0, 1'b0, 32'h0, 1'b0);

        // Contention, back to back: expect 0,1,0,1
        for (int t = 0; t < 4; t++) begin
            rand_reqs();
            run_xfer(2'b11, N'($urandom), 0, 1'b0, $urandom, 1'b0);
        end

        // Slave error then clean response
        rand_reqs();
        run_xfer(2'b01, 2'b00, 1, 1'b1, 32'hCAFE_0001, 1'b0);
        run_xfer(2'b01, 2'b00, 0, 1'b0, 32'hCAFE_0002, 1'b0);
        run_xfer(2'b00, 2'b00, 0, 1'b0, 32'h0, 1'b0);

        // Reset mid-ACCESS; requester 1 pending alone wins first
        rand_reqs();
        run_xfer(2'b10, 2'b00, 4, 1'b0, 32'h0, 1'b1);
        run_xfer(2'b10, 2'b00, 0, 1'b0, 32'h1111_2222, 1'b0);
        // Reset again; both pending resolves to requester 0
        rand_reqs();
        run_xfer(2'b01, 2'b01, 3, 1'b0, 32'h0, 1'b1);
        run_xfer(2'b11, 2'b00, 0, 1'b0, 32'h3333_4444, 1'b0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            rand_reqs();
            run_xfer(N'($urandom), N'($urandom), $urandom_range(0, 3),
                     1'(($urandom) & 1), $urandom, 1'b0);
        end
        run_xfer(2'b00, 2'b00, 0, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
